// File: rtl/word_splitter_seq.sv
// Sequential word splitter: accepts a WIDTH-bit word over valid/ready and emits
// WIDTH/LANE chunks, MSB- or LSB-first. Optional word counter under WORD_SPLITTER_CNT_EN.
module word_splitter_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANE  = 8,
    parameter int unsigned IDXW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANE-1:0]  out_data,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last
`ifdef WORD_SPLITTER_CNT_EN
    ,
    output logic [15:0]      word_cnt
`endif
);

    localparam int unsigned N = WIDTH / LANE;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic              order_msb;

    logic              in_fire;
    logic              out_fire;
    logic [WIDTH-1:0]  shreg_shifted;
    logic [IDXW-1:0]   idx_next;

    // Chunk 0 of a word in the requested order
    function automatic logic [LANE-1:0] head_chunk(input logic [WIDTH-1:0] w,
                                                   input logic msb);
        return msb ? w[WIDTH-1 -: LANE] : w[LANE-1:0];
    endfunction

    assign in_ready      = (state == IDLE) || (out_valid && out_ready && out_last);
    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    assign shreg_shifted = order_msb ? (shreg << LANE) : (shreg >> LANE);
    assign idx_next      = out_idx + IDXW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            order_msb <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (in_fire) begin
            // New word: present chunk 0 next cycle, even when finishing the previous word
            state     <= SEND;
            shreg     <= in_data;
            order_msb <= msb_first;
            out_valid <= 1'b1;
            out_data  <= head_chunk(in_data, msb_first);
            out_idx   <= '0;
            out_last  <= (N == 1);
        end else if (out_fire) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_idx   <= '0;
                out_last  <= 1'b0;
            end else begin
                shreg     <= shreg_shifted;
                out_data  <= head_chunk(shreg_shifted, order_msb);
                out_idx   <= idx_next;
                out_last  <= (idx_next == LAST_IDX);
            end
        end
    end

`ifdef WORD_SPLITTER_CNT_EN
    // Completed-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (out_fire && out_last) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_word_splitter_seq.sv
// Directed, scoreboard-based bench for word_splitter_seq (32/8 default and 16/4 instances).
module tb_word_splitter_seq;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        msb_first;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] in_data16;
    logic        out_valid16;
    logic        out_ready16;
    logic [3:0]  out_data16;
    logic [1:0]  out_idx16;
    logic        out_last16;

`ifdef WORD_SPLITTER_CNT_EN
    logic [15:0] word_cnt;
    logic [15:0] word_cnt16;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    beat_t q32[$];
    beat_t q16[$];

    word_splitter_seq u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .msb_first (msb_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef WORD_SPLITTER_CNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    word_splitter_seq #(.WIDTH(16), .LANE(4), .IDXW(2)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .msb_first (1'b1),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .out_idx   (out_idx16),
        .out_last  (out_last16)
`ifdef WORD_SPLITTER_CNT_EN
        ,
        .word_cnt  (word_cnt16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected chunks of a 32-bit word, 8-bit lanes
    task automatic push32(input logic [31:0] w, input logic msb);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.d    = 8'(msb ? (w >> (24 - 8 * k)) : (w >> (8 * k)));
            b.idx  = 2'(k);
            b.last = (k == 3);
            q32.push_back(b);
        end
    endtask

    // Expected chunks of a 16-bit word, 4-bit lanes, MSB-first
    task automatic push16(input logic [15:0] w);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.d    = 8'((w >> (12 - 4 * k)) & 16'h000F);
            b.idx  = 2'(k);
            b.last = (k == 3);
            q16.push_back(b);
        end
    endtask

    task automatic check_beat32();
        beat_t b;
        if (q32.size() == 0) begin
            chk("beat32_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
            b = q32.pop_front();
            chk("beat32_data", 32'(out_data), 32'(b.d));
            chk("beat32_idx",  32'(out_idx),  32'(b.idx));
            chk("beat32_last", 32'(out_last), 32'(b.last));
        end
    endtask

    task automatic check_beat16();
        beat_t b;
        if (q16.size() == 0) begin
            chk("beat16_unexpected", 32'(out_data16), 32'hFFFF_FFFF);
        end else begin
            b = q16.pop_front();
            chk("beat16_data", 32'(out_data16), 32'(b.d));
            chk("beat16_idx",  32'(out_idx16),  32'(b.idx));
            chk("beat16_last", 32'(out_last16), 32'(b.last));
        end
    endtask

    // Score any handshake about to happen, then advance one cycle
    task automatic tick();
        if (out_valid && out_ready)     check_beat32();
        if (out_valid16 && out_ready16) check_beat16();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        msb_first   = 1'b0;
        out_ready   = 1'b1;
        in_valid16  = 1'b0;
        in_data16   = '0;
        out_ready16 = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b0;
        tick();

        // MSB-first word
        in_valid = 1'b1; in_data = 32'h1234_5678; msb_first = 1'b1;
        chk("msb_in_ready", 32'(in_ready), 32'd1);
        push32(in_data, msb_first);
        tick();
        in_valid = 1'b0;
        chk("msb_latency_valid", 32'(out_valid), 32'd1);
        chk("msb_first_chunk",   32'(out_data),  32'h12);
        repeat (4) tick();
        chk("msb_idle_valid", 32'(out_valid), 32'd0);
        chk("msb_idle_ready", 32'(in_ready),  32'd1);

        // LSB-first, same word
        in_valid = 1'b1; msb_first = 1'b0;
        push32(in_data, msb_first);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("lsb_idle_valid", 32'(out_valid), 32'd0);

        // Stall on chunk 1 with a competing word offered
        in_valid = 1'b1; in_data = 32'hAABB_CCDD; msb_first = 1'b1;
        push32(in_data, msb_first);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 32'h5555_5555; msb_first = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data",     32'(out_data),  32'hBB);
            chk("stall_idx",      32'(out_idx),   32'd1);
            chk("stall_in_ready", 32'(in_ready),  32'd0);
            chk("stall_valid",    32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("stall_idle_valid", 32'(out_valid), 32'd0);
        chk("stall_q_empty",    32'(q32.size()), 32'd0);

        // Back-to-back words, second offered on the last beat
        in_valid = 1'b1; in_data = 32'h0102_0304; msb_first = 1'b1;
        push32(in_data, msb_first);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_busy_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("b2b_last_data",  32'(out_data), 32'h04);
        chk("b2b_last_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 32'hA0B0_C0D0;
        push32(in_data, msb_first);
        tick();
        in_valid = 1'b0;
        chk("b2b_no_bubble_valid", 32'(out_valid), 32'd1);
        chk("b2b_no_bubble_data",  32'(out_data),  32'hA0);
        chk("b2b_no_bubble_idx",   32'(out_idx),   32'd0);
        repeat (4) tick();
        chk("b2b_idle_valid", 32'(out_valid), 32'd0);

        // Reset while chunk 2 is presented
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        push32(in_data, msb_first);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("mid_chunk2", 32'(out_data), 32'hBE);
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        q32.delete();
        reset     = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_idx",   32'(out_idx),   32'd0);
        chk("mid_rst_last",  32'(out_last),  32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        tick();
        chk("mid_rst_no_residue", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_data = 32'h0000_0011;
        push32(in_data, msb_first);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("post_rst_idle", 32'(out_valid), 32'd0);
`ifdef WORD_SPLITTER_CNT_EN
        chk("word_cnt32", 32'(word_cnt), 32'd1);
`endif

        // 16-bit word, 4-bit lanes
        in_valid16 = 1'b1; in_data16 = 16'hF00D;
        push16(in_data16);
        tick();
        in_valid16 = 1'b0;
        chk("w16_first", 32'(out_data16), 32'hF);
        repeat (4) tick();
        chk("w16_idle_valid", 32'(out_valid16), 32'd0);
`ifdef WORD_SPLITTER_CNT_EN
        chk("word_cnt16", 32'(word_cnt16), 32'd1);
`endif

        chk("q32_drained", 32'(q32.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
